// File: rtl/mem_access_pkg.sv
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared encodings for the memory access unit: request opcodes,
//               FSM state enum and default address/data widths.
//               Optional feature macro: MEM_ACCESS_UNIT_ABORT_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 4;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_COPY  = 2'b10,
        OP_FILL  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        STORE   = 3'd2,
        COPY_RD = 3'd3,
        COPY_WR = 3'd4,
        FILL    = 3'd5,
        DONE    = 3'd6
    } state_e;

endpackage

`default_nettype wire

// File: rtl/mau_addr_gen.sv
// ============================================================================
// Module      : mau_addr_gen
// Description : Source/destination pointers and remaining-word counter for
//               the memory access unit. Pointers wrap modulo 2^ADDR_W.
//               Optional feature macro: MEM_ACCESS_UNIT_ABORT_EN (not used here)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mau_addr_gen #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] dst_init,
    input  logic [ADDR_W-1:0] src_init,
    input  logic [ADDR_W-1:0] len_init,
    output logic [ADDR_W-1:0] src_ptr,
    output logic [ADDR_W-1:0] dst_ptr,
    output logic              last
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] remain;

    // Load pointers on accept; advance both pointers and count down per word.
    // Natural ADDR_W-bit overflow gives the modulo-2^ADDR_W wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_ptr <= '0;
            dst_ptr <= '0;
            remain  <= '0;
        end else if (load) begin
            src_ptr <= src_init;
            dst_ptr <= dst_init;
            remain  <= len_init;
        end else if (step) begin
            src_ptr <= src_ptr + ONE;
            dst_ptr <= dst_ptr + ONE;
            remain  <= remain - ONE;
        end
    end

    // Count holds "words left minus one", so zero marks the final word.
    assign last = (remain == '0);

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module      : mem_access_unit
// Description : Single-port memory sequencer executing LOAD, STORE, COPY and
//               FILL requests with a one-cycle completion pulse.
//               Optional feature macro: MEM_ACCESS_UNIT_ABORT_EN adds the
//               abort input and rsp_aborted output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_src,
    input  logic [ADDR_W-1:0] req_len,
    input  logic [DATA_W-1:0] req_data,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
`ifdef MEM_ACCESS_UNIT_ABORT_EN
    input  logic              abort,
    output logic              rsp_aborted,
`endif
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state;
    state_e            next_state;
    logic              accept;
    logic              ag_step;
    logic              last;
    logic              abort_w;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] hold_q;

`ifdef MEM_ACCESS_UNIT_ABORT_EN
    // Abort only has meaning in the multi-word states.
    assign abort_w = abort && ((state == COPY_RD) || (state == COPY_WR) || (state == FILL));
`else
    assign abort_w = 1'b0;
`endif

    assign req_ready = (state == IDLE);
    assign busy      = !req_ready;
    assign rsp_valid = (state == DONE);
    assign accept    = req_valid && req_ready;

    mau_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .step     (ag_step),
        .dst_init (req_addr),
        .src_init (req_src),
        .len_init (req_len),
        .src_ptr  (src_ptr),
        .dst_ptr  (dst_ptr),
        .last     (last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and memory-port decode; unused port fields stay at zero.
    always_comb begin
        next_state = state;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        ag_step    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    case (op_e'(req_op))
                        OP_LOAD:  next_state = LOAD;
                        OP_STORE: next_state = STORE;
                        OP_COPY:  next_state = COPY_RD;
                        OP_FILL:  next_state = FILL;
                        default:  next_state = IDLE;
                    endcase
                end
            end
            LOAD: begin
                mem_addr   = dst_ptr;
                next_state = DONE;
            end
            STORE: begin
                mem_wr     = 1'b1;
                mem_addr   = dst_ptr;
                mem_wdata  = data_q;
                next_state = DONE;
            end
            COPY_RD: begin
                mem_addr   = src_ptr;
                next_state = abort_w ? DONE : COPY_WR;
            end
            COPY_WR: begin
                mem_wr     = 1'b1;
                mem_addr   = dst_ptr;
                mem_wdata  = hold_q;
                ag_step    = 1'b1;
                next_state = (last || abort_w) ? DONE : COPY_RD;
            end
            FILL: begin
                mem_wr     = 1'b1;
                mem_addr   = dst_ptr;
                mem_wdata  = data_q;
                ag_step    = 1'b1;
                next_state = (last || abort_w) ? DONE : FILL;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request data, copy hold word and response word; the response is
    // written on the edge entering DONE and then held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= '0;
            hold_q   <= '0;
            rsp_data <= '0;
        end else begin
            if (accept) begin
                data_q <= req_data;
            end
            case (state)
                LOAD:    rsp_data <= mem_rdata;
                STORE:   rsp_data <= data_q;
                COPY_RD: if (!abort_w) hold_q <= mem_rdata;
                COPY_WR: if (next_state == DONE) rsp_data <= hold_q;
                FILL:    if (next_state == DONE) rsp_data <= data_q;
                default: ;
            endcase
        end
    end

`ifdef MEM_ACCESS_UNIT_ABORT_EN
    logic aborted_q;

    // Remember an abort until the next request is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aborted_q <= 1'b0;
        end else if (accept) begin
            aborted_q <= 1'b0;
        end else if (abort_w) begin
            aborted_q <= 1'b1;
        end
    end

    assign rsp_aborted = (state == DONE) && aborted_q;
`endif

endmodule

`default_nettype wire
